noc_vc_sched: RTL and testbench
===============================

# noc_vc_sched

Packet-level scheduler that shares one NoC output link between `N_REQ` local requesters. It arbitrates round-robin per packet and holds the grant until the `last` beat, so packets never interleave. Each virtual channel has a credit counter mirroring free space in the downstream VC FIFO. The block sits between client-side packetizers and a router input port, and its beats use the `noc_packet_s` field layout (data, last, addr).

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (≥2).
- `D_W`, `DEFAULT_D_W` (32): payload data width.
- `A_W`, `DEFAULT_A_W` (4): address width.
- `VC_W`, `DEFAULT_VC_W` (2): number of VCs, one-hot encoded.
- `VC_FIFO_DEPTH`, `DEFAULT_VC_FIFO_DEPTH` (64): credit count after reset is `VC_FIFO_DEPTH-1`.
- `CNT_W`, `DEFAULT_VC_COUNTER_W` (6): credit counter width.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `N_REQ`: per-requester beat valid.
- `req_ready` out `N_REQ`: per-requester beat accept.
- `req_data` in `N_REQ*D_W`: per-requester data, requester i at bits `[i*D_W +: D_W]`.
- `req_last` in `N_REQ`: last beat of packet.
- `req_addr` in `N_REQ*A_W`: destination address.
- `req_vc` in `N_REQ*VC_W`: one-hot VC; sampled only on the first beat.
- `out_valid` out 1, `out_ready` in 1: link handshake.
- `out_data` out `D_W`, `out_last` out 1, `out_addr` out `A_W`, `out_vc` out `VC_W`: registered beat.
- `credit_return` in `VC_W`: per-VC pulse; downstream freed one entry.
- `credit_cnt` out `VC_W*CNT_W`: current credits per VC.
- `grant_id` out `$clog2(N_REQ)`: current/last owner.
- `locked` out 1: packet in progress.
- `credit_err` out 1: sticky error flag.

## Operation
- **State machine**: IDLE and LOCKED. `locked` = (state==LOCKED).
- **Output register**:
  - `load_ok = !out_valid || out_ready`.
  - A beat loads from requester r when `req_valid[r] && req_ready[r]`.
- **IDLE**:
  - Eligible requester i: `req_valid[i]`, `req_vc` slice is exactly one-hot, and credit of that VC > 0.
  - Winner is the first eligible requester starting at `rr_ptr+1` (mod `N_REQ`).
  - If `load_ok`, `req_ready[winner]=1` and the beat loads this cycle.
  - The winner's VC is latched as `cur_vc`, and `grant_id` = winner.
  - If the beat is not last, go to LOCKED. If it is last, stay in IDLE and set `rr_ptr` = winner.
  - If `load_ok=0`, no grant is made and the state does not change.
- **LOCKED**:
  - Only the owner is served: `req_ready[owner] = load_ok && credit[cur_vc]>0`.
  - `req_vc` is ignored; `out_vc = cur_vc` for every beat.
  - When the last beat loads, go to IDLE and set `rr_ptr` = owner.
  - No other requester is granted while LOCKED, even when the owner stalls or is out of credit.
- **Credits**: per VC, `cnt_next = cnt - consume + ret`.
  - `consume` = a beat loaded on this VC.
  - `ret` = `credit_return` bit.
  - Consume and return in the same cycle leaves the count unchanged.
  - A return that would exceed `VC_FIFO_DEPTH-1` is dropped and sets `credit_err`.
  - Consume at 0 cannot occur, because ready is gated on credit > 0.
- **Non-one-hot `req_vc`** on a first beat: that requester is never eligible and is never readied.
- `credit_err` is cleared only by reset.

## Timing
- **Reset** (async assert; release is synchronous to `clk` via the normal flop path):
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_addr=0`, `out_vc=0`.
  - `req_ready=0` while reset is asserted.
  - State IDLE, `locked=0`, `grant_id=0`, `rr_ptr=N_REQ-1` (requester 0 has first priority), `cur_vc=0`.
  - All credits = `VC_FIFO_DEPTH-1`, `credit_err=0`.
- **Reset mid-packet**: the packet is abandoned, the output beat is dropped, and credits are reinitialised.
- **Latency and throughput**: 1 cycle from request handshake to `out_valid`. Throughput is 1 beat/cycle when `out_ready` stays high.
- **Combinational paths**: `req_ready` depends on `out_ready`, `out_valid`, credits and state. `req_ready` does not depend on `req_valid` of the same requester, except through IDLE eligibility.
- **Holding rules**:
  - `out_*` hold stable while `out_valid && !out_ready`.
  - Requesters must hold beats until ready.
- **Credit visibility**: a credit return is visible in `credit_cnt` and in eligibility on the next cycle.
- **Back-to-back packets**: a new packet may be granted in the cycle after a last beat loads, so there is no bubble.

## Test plan
- **Single-beat basics**: after reset, requester 0 sends one beat (`last=1`, data `0xA5A5A5A5`, addr 3, vc `2'b01`), `out_ready=1` → next cycle `out_valid=1`, `out_data=0xA5A5A5A5`, `out_vc=01`. VC0 credits go 63 → 62 and then stay at 62.
- **Round-robin and locking**: all 4 requesters send 3-beat packets continuously → output order is full packets from 0, 1, 2, 3, 0, … with no interleaving, 12 beats in 12 consecutive cycles, and `locked` high during beats 1–2 of each packet.
- **Credit exhaustion**: block all credit returns and stream on VC1 → exactly 63 beats transfer and then `req_ready=0`. Pulse `credit_return[1]` once → exactly one more beat, while other requesters stay blocked if mid-packet.
- **Simultaneous events and saturation**: consume and return on VC0 in the same cycle → count unchanged. A return at count 63 → count stays 63 and `credit_err=1`.
- **Backpressure**: hold `out_ready=0` for 5 cycles mid-packet → `out_*` stable and `req_ready=0`. On release, the transfer resumes with no beat lost or duplicated.
- **Reset mid-packet**: assert `rst_n=0` during beat 2 of a 4-beat packet → `out_valid` drops immediately and credits read 63. After release, requester 0 has first priority.

Source files
------------

// File: rtl/noc_vc_sched.sv
// Packet-level round-robin scheduler that shares one NoC link among N_REQ requesters.
// Per-VC credit counters mirror free space in the downstream VC FIFOs.
module noc_vc_sched #(
  parameter int N_REQ         = 4,
  parameter int D_W           = 32,
  parameter int A_W           = 4,
  parameter int VC_W          = 2,
  parameter int VC_FIFO_DEPTH = 64,
  parameter int CNT_W         = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*D_W-1:0]     req_data,
  input  logic [N_REQ-1:0]         req_last,
  input  logic [N_REQ*A_W-1:0]     req_addr,
  input  logic [N_REQ*VC_W-1:0]    req_vc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [D_W-1:0]           out_data,
  output logic                     out_last,
  output logic [A_W-1:0]           out_addr,
  output logic [VC_W-1:0]          out_vc,
  input  logic [VC_W-1:0]          credit_return,
  output logic [VC_W*CNT_W-1:0]    credit_cnt,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     locked,
  output logic                     credit_err
);
  localparam int ID_W = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(VC_FIFO_DEPTH - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  rr_q, rr_d, gid_q, gid_d, winner, load_sel;
  logic [VC_W-1:0]  cur_vc_q, cur_vc_d, load_vc, credit_nz, consume;
  logic [CNT_W-1:0] cnt_q [VC_W];
  logic [N_REQ-1:0] eligible, ready_int;
  logic             found, load_ok, load, load_last;

  always_comb begin
    for (int v = 0; v < VC_W; v++) credit_nz[v] = (cnt_q[v] != '0);
  end

  // A requester whose VC field is not exactly one-hot can never become eligible.
  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      eligible[i] = req_valid[i] && $onehot(req_vc[i*VC_W +: VC_W])
                    && |(req_vc[i*VC_W +: VC_W] & credit_nz);
  end

  always_comb begin
    found  = 1'b0;
    winner = rr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && eligible[(int'(rr_q) + k) % N_REQ]) begin
        found  = 1'b1;
        winner = ID_W'((int'(rr_q) + k) % N_REQ);
      end
    end
  end

  assign load_ok = !out_valid || out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    rr_d      = rr_q;
    gid_d     = gid_q;
    cur_vc_d  = cur_vc_q;
    ready_int = '0;
    load      = 1'b0;
    load_sel  = gid_q;
    load_vc   = cur_vc_q;
    case (state_q)
      IDLE: begin
        if (found && load_ok) begin
          ready_int[winner] = 1'b1;
          load     = 1'b1;
          load_sel = winner;
          load_vc  = req_vc[winner*VC_W +: VC_W];
          gid_d    = winner;
          cur_vc_d = req_vc[winner*VC_W +: VC_W];
          if (req_last[winner]) rr_d = winner;
          else                  state_d = LOCKED;
        end
      end
      LOCKED: begin
        // The owner keeps the link even while stalled; nobody else is considered.
        ready_int[gid_q] = load_ok && |(cur_vc_q & credit_nz);
        load = ready_int[gid_q] && req_valid[gid_q];
        if (load && req_last[gid_q]) begin
          state_d = IDLE;
          rr_d    = gid_q;
        end
      end
    endcase
  end

  assign load_last = req_last[load_sel];
  assign consume   = load ? load_vc : '0;
  assign req_ready = rst_n ? ready_int : '0;
  assign locked    = (state_q == LOCKED);
  assign grant_id  = gid_q;

  always_comb begin
    for (int v = 0; v < VC_W; v++) credit_cnt[v*CNT_W +: CNT_W] = cnt_q[v];
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_q     <= ID_W'(N_REQ - 1);
      gid_q    <= '0;
      cur_vc_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      gid_q    <= gid_d;
      cur_vc_q <= cur_vc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_addr  <= '0;
      out_vc    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= req_data[load_sel*D_W +: D_W];
      out_last  <= load_last;
      out_addr  <= req_addr[load_sel*A_W +: A_W];
      out_vc    <= load_vc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // NOTE: the credit array is a handful of flops, not a RAM, so it is reset like any
  // other state; a return at full count is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < VC_W; v++) cnt_q[v] <= CNT_MAX;
      credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < VC_W; v++) begin
        if (credit_return[v] && !consume[v] && cnt_q[v] == CNT_MAX)
          credit_err <= 1'b1;
        else
          cnt_q[v] <= cnt_q[v] + CNT_W'(credit_return[v]) - CNT_W'(consume[v]);
      end
    end
  end

endmodule

// File: tb/tb_noc_vc_sched.sv
// Self-checking bench for noc_vc_sched: vector table, directed multi-cycle sequences,
// and a randomized phase compared against a transaction-level reference model.
module tb_noc_vc_sched;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int VW = 2;
  localparam int CW = 6;
  localparam int NV = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready, req_last;
  logic [N*DW-1:0] req_data;
  logic [N*AW-1:0] req_addr;
  logic [N*VW-1:0] req_vc;
  logic            out_valid, out_ready, out_last;
  logic [DW-1:0]   out_data;
  logic [AW-1:0]   out_addr;
  logic [VW-1:0]   out_vc, credit_return;
  logic [VW*CW-1:0] credit_cnt;
  logic [1:0]      grant_id;
  logic            locked, credit_err;

  int n_checks = 0;
  int n_errors = 0;

  noc_vc_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .req_last(req_last), .req_addr(req_addr), .req_vc(req_vc),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_addr(out_addr), .out_vc(out_vc),
    .credit_return(credit_return), .credit_cnt(credit_cnt),
    .grant_id(grant_id), .locked(locked), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0; req_addr = '0; req_vc = '0;
    credit_return = '0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0]  valid;
    logic          last;
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
    logic [VW-1:0] vc;
    logic          ordy;
    logic [VW-1:0] ret;
    logic [N-1:0]  e_ready;
    logic          e_ov;
    logic [DW-1:0] e_data;
    logic [VW-1:0] e_vc;
    logic [CW-1:0] e_c0, e_c1;
    logic          e_err, e_locked;
    logic [1:0]    e_gid;
  } vec_t;

  vec_t vecs[NV];

  // ---------------- reference model state ----------------
  bit            m_inpkt, m_ov, m_err, m_last;
  int            m_owner, m_rr, m_gid;
  int            m_cnt[VW];
  logic [DW-1:0] m_data;
  logic [AW-1:0] m_addr;
  logic [VW-1:0] m_vc, m_cur_vc;

  // per-requester traffic generator state
  bit            pres[N], first[N], blast[N];
  int            rem[N];
  logic [VW-1:0] pvc[N], bvc[N];
  logic [DW-1:0] bdata[N];
  logic [AW-1:0] baddr[N];

  logic [DW-1:0] got[$];

  task automatic model_reset();
    m_inpkt = 0; m_ov = 0; m_err = 0; m_last = 0;
    m_owner = 0; m_rr = N - 1; m_gid = 0;
    for (int v = 0; v < VW; v++) m_cnt[v] = 63;
    m_data = '0; m_addr = '0; m_vc = '0; m_cur_vc = '0;
  endtask

  // Who should be readied this cycle, derived from the arbitration rules.
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0]  r;
    logic [VW-1:0] v;
    bit            lok, done;
    int            i;
    r = '0; done = 0;
    lok = !m_ov || out_ready;
    if (!m_inpkt) begin
      for (int k = 1; k <= N; k++) begin
        i = (m_rr + k) % N;
        v = req_vc[i*VW +: VW];
        if (!done && req_valid[i] && $onehot(v) && m_cnt[v[1]] > 0) begin
          done = 1;
          if (lok) r[i] = 1'b1;
        end
      end
    end else if (lok && m_cnt[m_cur_vc[1]] > 0) begin
      r[m_owner] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_step(input logic [N-1:0] hs);
    logic [VW-1:0] vcl;
    int  w;
    bit  cons;
    vcl = '0; w = 0;
    for (int i = 0; i < N; i++) if (hs[i]) w = i;
    if (hs != '0) begin
      vcl = m_inpkt ? m_cur_vc : req_vc[w*VW +: VW];
      if (!m_inpkt) begin
        m_owner = w; m_gid = w; m_cur_vc = vcl;
        if (req_last[w]) m_rr = w; else m_inpkt = 1;
      end else if (req_last[w]) begin
        m_inpkt = 0; m_rr = m_owner;
      end
      m_ov = 1; m_data = req_data[w*DW +: DW]; m_last = req_last[w];
      m_addr = req_addr[w*AW +: AW]; m_vc = vcl;
    end else if (out_ready) begin
      m_ov = 0;
    end
    for (int v = 0; v < VW; v++) begin
      cons = (hs != '0) && vcl[v];
      if (credit_return[v] && !cons && m_cnt[v] == 63) m_err = 1;
      else m_cnt[v] = m_cnt[v] + int'(credit_return[v]) - int'(cons);
    end
  endtask

  task automatic model_compare();
    check("rnd_out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("rnd_out_data", out_data, m_data);
      check("rnd_out_last", out_last, m_last);
      check("rnd_out_addr", out_addr, m_addr);
      check("rnd_out_vc",   out_vc,   m_vc);
    end
    check("rnd_credit0", credit_cnt[5:0],  m_cnt[0]);
    check("rnd_credit1", credit_cnt[11:6], m_cnt[1]);
    check("rnd_err",     credit_err, m_err);
    check("rnd_locked",  locked,     m_inpkt);
    check("rnd_grant",   grant_id,   m_gid);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] hs, er;
    logic [DW-1:0] held;
    int bi[N], pk[N];
    int n, n1, n2, b, ret_odds;

    vecs[0]  = '{4'b0001, 1'b1, 32'hA5A5A5A5, 4'd3, 2'b01, 1'b1, 2'b00, 4'b0001, 1'b1, 32'hA5A5A5A5, 2'b01, 6'd62, 6'd63, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{4'b0000, 1'b1, 32'hA5A5A5A5, 4'd3, 2'b01, 1'b1, 2'b00, 4'b0000, 1'b0, 32'h0,        2'b01, 6'd62, 6'd63, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{4'b0000, 1'b1, 32'hA5A5A5A5, 4'd3, 2'b01, 1'b1, 2'b00, 4'b0000, 1'b0, 32'h0,        2'b01, 6'd62, 6'd63, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{4'b0010, 1'b1, 32'h11111111, 4'd5, 2'b01, 1'b1, 2'b01, 4'b0010, 1'b1, 32'h11111111, 2'b01, 6'd62, 6'd63, 1'b0, 1'b0, 2'd1};
    vecs[4]  = '{4'b0000, 1'b1, 32'h11111111, 4'd5, 2'b01, 1'b1, 2'b01, 4'b0000, 1'b0, 32'h0,        2'b01, 6'd63, 6'd63, 1'b0, 1'b0, 2'd1};
    vecs[5]  = '{4'b0000, 1'b1, 32'h11111111, 4'd5, 2'b01, 1'b1, 2'b01, 4'b0000, 1'b0, 32'h0,        2'b01, 6'd63, 6'd63, 1'b1, 1'b0, 2'd1};
    vecs[6]  = '{4'b0100, 1'b1, 32'h0,        4'd0, 2'b11, 1'b1, 2'b10, 4'b0000, 1'b0, 32'h0,        2'b01, 6'd63, 6'd63, 1'b1, 1'b0, 2'd1};
    vecs[7]  = '{4'b1111, 1'b0, 32'h22222222, 4'd7, 2'b10, 1'b0, 2'b00, 4'b0100, 1'b1, 32'h22222222, 2'b10, 6'd63, 6'd62, 1'b1, 1'b1, 2'd2};
    vecs[8]  = '{4'b1111, 1'b0, 32'h22222222, 4'd7, 2'b10, 1'b0, 2'b00, 4'b0000, 1'b1, 32'h22222222, 2'b10, 6'd63, 6'd62, 1'b1, 1'b1, 2'd2};
    vecs[9]  = '{4'b1111, 1'b1, 32'h33333333, 4'd8, 2'b01, 1'b1, 2'b00, 4'b0100, 1'b1, 32'h33333333, 2'b10, 6'd63, 6'd61, 1'b1, 1'b0, 2'd2};
    vecs[10] = '{4'b1111, 1'b1, 32'h44444444, 4'd9, 2'b01, 1'b1, 2'b00, 4'b1000, 1'b1, 32'h44444444, 2'b01, 6'd62, 6'd61, 1'b1, 1'b0, 2'd3};

    // ---- reset state, with requests pending during reset ----
    rst_n = 1'b0; out_ready = 1'b1; credit_return = '0;
    req_valid = '1; req_last = '1; req_vc = {N{2'b01}}; req_data = '1; req_addr = '1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready",     req_ready, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  32'h0);
    check("rst_out_last",  out_last,  1'b0);
    check("rst_out_addr",  out_addr,  4'h0);
    check("rst_out_vc",    out_vc,    2'b00);
    check("rst_locked",    locked,    1'b0);
    check("rst_grant",     grant_id,  2'd0);
    check("rst_credits",   credit_cnt, {6'd63, 6'd63});
    check("rst_err",       credit_err, 1'b0);

    // ---- vector table ----
    do_reset();
    for (int r = 0; r < NV; r++) begin
      req_valid = vecs[r].valid;     req_last = {N{vecs[r].last}};
      req_data  = {N{vecs[r].data}}; req_addr = {N{vecs[r].addr}};
      req_vc    = {N{vecs[r].vc}};   out_ready = vecs[r].ordy;
      credit_return = vecs[r].ret;
      #1 check($sformatf("vec%0d_ready", r), req_ready, vecs[r].e_ready);
      @(negedge clk);
      check($sformatf("vec%0d_out_valid", r), out_valid, vecs[r].e_ov);
      if (vecs[r].e_ov) begin
        check($sformatf("vec%0d_out_data", r), out_data, vecs[r].e_data);
        check($sformatf("vec%0d_out_vc", r),   out_vc,   vecs[r].e_vc);
      end
      check($sformatf("vec%0d_credit0", r), credit_cnt[5:0],  vecs[r].e_c0);
      check($sformatf("vec%0d_credit1", r), credit_cnt[11:6], vecs[r].e_c1);
      check($sformatf("vec%0d_err", r),     credit_err, vecs[r].e_err);
      check($sformatf("vec%0d_locked", r),  locked,     vecs[r].e_locked);
      check($sformatf("vec%0d_grant", r),   grant_id,   vecs[r].e_gid);
    end

    // ---- round-robin with 3-beat packets from every requester ----
    do_reset();
    for (int i = 0; i < N; i++) begin bi[i] = 0; pk[i] = 0; end
    for (int c = 0; c <= 13; c++) begin
      if (c >= 1) begin
        n = c - 1;
        check("rr_out_valid", out_valid, 1'b1);
        check($sformatf("rr_beat%0d_data", n), out_data,
              {8'h0, 8'((n / 3) % N), 8'(n / 12), 8'(n % 3)});
        check($sformatf("rr_beat%0d_locked", n), locked, (n % 3) != 2);
      end
      if (c == 13) check("rr_credit0", credit_cnt[5:0], 6'd50);
      req_valid = '1; req_vc = {N{2'b01}};
      for (int i = 0; i < N; i++) begin
        req_data[i*DW +: DW] = {8'h0, 8'(i), 8'(pk[i]), 8'(bi[i])};
        req_last[i] = (bi[i] == 2);
      end
      #1 hs = req_valid & req_ready;
      check("rr_one_beat_per_cycle", $countones(hs), 1);
      for (int i = 0; i < N; i++)
        if (hs[i]) begin
          if (bi[i] == 2) begin bi[i] = 0; pk[i]++; end
          else bi[i]++;
        end
      @(negedge clk);
    end
    req_valid = '0;

    // ---- credit exhaustion on VC1 with a competing requester on VC0 ----
    do_reset();
    n1 = 0; n2 = 0;
    for (int c = 0; c < 75; c++) begin
      req_valid[1] = 1'b1; req_vc[3:2] = 2'b10; req_last[1] = 1'b0; req_data[63:32] = 32'(c);
      req_valid[2] = (c >= 5); req_vc[5:4] = 2'b01; req_last[2] = 1'b1;
      #1;
      if (req_valid[1] && req_ready[1]) n1++;
      if (req_valid[2] && req_ready[2]) n2++;
      @(negedge clk);
    end
    check("exh_beats", n1, 63);
    check("exh_other_blocked", n2, 0);
    check("exh_credit1", credit_cnt[11:6], 6'd0);
    check("exh_credit0", credit_cnt[5:0], 6'd63);
    #1 check("exh_ready", req_ready, 4'b0000);
    n1 = 0; n2 = 0;
    for (int k = 0; k < 7; k++) begin
      credit_return = (k == 0) ? 2'b10 : 2'b00;
      #1;
      if (req_valid[1] && req_ready[1]) n1++;
      if (req_valid[2] && req_ready[2]) n2++;
      @(negedge clk);
    end
    check("exh_one_more_beat", n1, 1);
    check("exh_other_still_blocked", n2, 0);
    check("exh_credit1_after", credit_cnt[11:6], 6'd0);

    // ---- backpressure mid-packet ----
    do_reset();
    got.delete();
    b = 0; held = '0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      req_valid[0] = (b < 6); req_data[31:0] = 32'h100 + 32'(b);
      req_last[0] = (b == 5); req_vc[1:0] = 2'b01; req_addr[3:0] = 4'd2;
      #1;
      if (c >= 3 && c <= 7) begin
        check("bp_ready", req_ready, 4'b0000);
        check("bp_out_valid", out_valid, 1'b1);
        if (c == 3) held = out_data;
        else check("bp_out_stable", out_data, held);
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (req_valid[0] && req_ready[0]) b++;
      @(negedge clk);
    end
    check("bp_beat_count", got.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("bp_beat%0d", i), (got.size() > i) ? got[i] : 32'hDEADBEEF, 32'h100 + 32'(i));

    // ---- reset in the middle of a 4-beat packet ----
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req_valid = 4'b0001; req_vc[1:0] = 2'b10; req_last[0] = 1'b0;
      req_data[31:0] = 32'h200 + 32'(k);
      #1 check("rstm_ready", req_ready, 4'b0001);
      @(negedge clk);
    end
    req_data[31:0] = 32'h202;
    check("rstm_pre_data", out_data, 32'h201);
    check("rstm_pre_locked", locked, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstm_out_valid", out_valid, 1'b0);
    check("rstm_credits", credit_cnt, {6'd63, 6'd63});
    check("rstm_locked", locked, 1'b0);
    check("rstm_ready", req_ready, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 4'b0011; req_last = 4'b0011; req_vc[3:0] = 4'b0101;
    req_data[31:0] = 32'h300; req_data[63:32] = 32'h301;
    #1 check("rstm_priority", req_ready, 4'b0001);
    @(negedge clk);
    check("rstm_first_beat", out_data, 32'h300);
    req_valid = '0;

    // ---- randomized traffic against the reference model ----
    do_reset();
    model_reset();
    for (int i = 0; i < N; i++) begin pres[i] = 0; rem[i] = 0; first[i] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      model_compare();
      for (int i = 0; i < N; i++) begin
        if (!pres[i]) begin
          if ($urandom_range(3) != 0) begin
            if (rem[i] == 0) begin
              rem[i] = $urandom_range(1, 4);
              first[i] = 1;
              if ($urandom_range(7) == 0) pvc[i] = $urandom_range(1) ? 2'b00 : 2'b11;
              else                        pvc[i] = $urandom_range(1) ? 2'b01 : 2'b10;
            end
            pres[i] = 1;
            bdata[i] = $urandom;
            baddr[i] = 4'($urandom);
            blast[i] = (rem[i] == 1);
            bvc[i] = first[i] ? pvc[i] : 2'($urandom);
          end
        end else if (first[i] && !$onehot(pvc[i]) && $urandom_range(1) == 1) begin
          pres[i] = 0; rem[i] = 0;
        end
        req_valid[i] = pres[i];
        req_data[i*DW +: DW] = bdata[i];
        req_addr[i*AW +: AW] = baddr[i];
        req_vc[i*VW +: VW]   = bvc[i];
        req_last[i] = blast[i];
      end
      ret_odds = (cyc < 1500) ? 7 : 1;
      credit_return = {$urandom_range(ret_odds) == 0, $urandom_range(ret_odds) == 0};
      out_ready = ($urandom_range(3) != 0);
      #1;
      er = model_ready();
      check("rnd_ready", req_ready, er);
      hs = req_valid & er;
      model_step(hs);
      for (int i = 0; i < N; i++)
        if (hs[i]) begin pres[i] = 0; rem[i]--; first[i] = 0; end
      @(negedge clk);
    end
    model_compare();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
